// File: rtl/zero_gate_pipe_pkg.sv
// Shared types and constants for the zero_gate_pipe detector.
package zero_gate_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    ACK   = 2'd2
  } state_e;

  typedef enum logic {
    MODE_INT   = 1'b0,
    MODE_FLOAT = 1'b1
  } mode_e;

  // Half-precision style exponent field location
  localparam int unsigned FP_EXP_LO = 10;
  localparam int unsigned FP_EXP_HI = 14;

endpackage

// File: rtl/zero_gate_pipe_if.sv
// Beat handshake bundle: input side (i_*/o_ready) and output side (o_*/i_ready).
interface zero_gate_pipe_if #(
  parameter int unsigned IA_W    = 16,
  parameter int unsigned IB_W    = 16,
  parameter int unsigned N_LANES = 4
);

  logic                      i_valid;
  logic                      o_ready;
  logic [N_LANES*IA_W-1:0]   i_a;
  logic [N_LANES*IB_W-1:0]   i_b;
  logic                      o_valid;
  logic                      i_ready;
  logic [N_LANES*IA_W-1:0]   o_a;
  logic [N_LANES*IB_W-1:0]   o_b;
  logic [N_LANES-1:0]        o_zero_det;

  // Detector side
  modport slave (
    input  i_valid, i_a, i_b, i_ready,
    output o_ready, o_valid, o_a, o_b, o_zero_det
  );

  // Producer/consumer side
  modport master (
    output i_valid, i_a, i_b, i_ready,
    input  o_ready, o_valid, o_a, o_b, o_zero_det
  );

endinterface

// File: rtl/zero_gate_pipe_zero_det_lane.sv
// Combinational zero/negligence detector for one activation/weight pair.
module zero_det_lane
  import zero_gate_pkg::*;
#(
  parameter int unsigned IA_W   = 16,
  parameter int unsigned IB_W   = 16,
  parameter int unsigned TH_W   = 2,
  parameter int unsigned EXP_LO = FP_EXP_LO,
  parameter int unsigned EXP_HI = FP_EXP_HI
) (
  input  logic [IA_W-1:0] a,
  input  logic [IB_W-1:0] b,
  input  logic [TH_W-1:0] thres,
  input  mode_e           mode,
  output logic            det
);

  logic [IA_W-1:0]          a_hi, a_inv_hi;
  logic [IB_W-1:0]          b_hi, b_inv_hi;
  logic [EXP_HI-EXP_LO:0]   exp_a_hi, exp_b_hi;
  logic                     neg_a, neg_b;

  // Shifting right by t leaves only the bits [W-1:t] / [EXP_HI:EXP_LO+t];
  // an empty exponent field shifts to zero, which reads as negligible.
  always_comb begin
    a_hi     = a >> thres;
    a_inv_hi = (~a) >> thres;
    b_hi     = b >> thres;
    b_inv_hi = (~b) >> thres;
    exp_a_hi = a[EXP_HI:EXP_LO] >> thres;
    exp_b_hi = b[EXP_HI:EXP_LO] >> thres;
    neg_a    = 1'b0;
    neg_b    = 1'b0;
    if (thres != '0) begin
      if (mode == MODE_INT) begin
        neg_a = (a_hi == '0) || (a_inv_hi == '0);
        neg_b = (b_hi == '0) || (b_inv_hi == '0);
      end else begin
        neg_a = (exp_a_hi == '0);
        neg_b = (exp_b_hi == '0);
      end
    end
  end

  assign det = (a == '0) || (b == '0) || (neg_a && neg_b);

endmodule

// File: rtl/zero_gate_pipe.sv
// Multi-lane pipelined zero/negligence gate with drained config changes and
// saturating gate statistics.
module zero_gate_pipe
  import zero_gate_pkg::*;
#(
  parameter int unsigned IA_W    = 16,
  parameter int unsigned IB_W    = 16,
  parameter int unsigned TH_W    = 2,
  parameter int unsigned N_LANES = 4,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned EXP_LO  = FP_EXP_LO,
  parameter int unsigned EXP_HI  = FP_EXP_HI
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  zero_gate_pipe_if.slave   bus,
  input  logic              i_cfg_req,
  input  logic [TH_W-1:0]   i_cfg_thres,
  input  logic              i_cfg_mode,
  output logic              o_cfg_ack,
  input  logic              i_cnt_clr,
  output logic [CNT_W-1:0]  o_skip_cnt,
  output logic [CNT_W-1:0]  o_total_cnt
);

  state_e                   state, state_nxt;
  logic [TH_W-1:0]          thres_q;
  mode_e                    mode_q;
  logic                     ready, ack, cfg_load;
  logic                     take, give;
  logic                     valid_q;
  logic [N_LANES*IA_W-1:0]  a_q;
  logic [N_LANES*IB_W-1:0]  b_q;
  logic [N_LANES-1:0]       det_q, det_vec;
  logic [CNT_W-1:0]         skip_q, total_q;
  logic [CNT_W:0]           pop, skip_sum, total_sum;

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    zero_det_lane #(
      .IA_W   (IA_W),
      .IB_W   (IB_W),
      .TH_W   (TH_W),
      .EXP_LO (EXP_LO),
      .EXP_HI (EXP_HI)
    ) u_lane (
      .a     (bus.i_a[k*IA_W +: IA_W]),
      .b     (bus.i_b[k*IB_W +: IB_W]),
      .thres (thres_q),
      .mode  (mode_q),
      .det   (det_vec[k])
    );
  end

  assign take = bus.i_valid && ready;
  assign give = valid_q && bus.i_ready;

  // Next state, input ready and config-latch strobe
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    ack       = 1'b0;
    cfg_load  = 1'b0;
    case (state)
      RUN: begin
        ready = !valid_q || bus.i_ready;
        if (i_cfg_req) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!valid_q || bus.i_ready) begin
          cfg_load  = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        ack       = 1'b1;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= RUN;
    else         state <= state_nxt;
  end

  // Active threshold/mode, replaced only once the pipe is drained
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      thres_q <= '0;
      mode_q  <= MODE_INT;
    end else if (cfg_load) begin
      thres_q <= i_cfg_thres;
      mode_q  <= mode_e'(i_cfg_mode);
    end
  end

  // Output register: load on accept, hold while stalled, empty on transfer
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      det_q   <= '0;
    end else if (take) begin
      valid_q <= 1'b1;
      a_q     <= bus.i_a;
      b_q     <= bus.i_b;
      det_q   <= det_vec;
    end else if (give) begin
      valid_q <= 1'b0;
    end
  end

  // Counter increments with one spare carry bit for saturation detect
  always_comb begin
    pop = '0;
    for (int unsigned k = 0; k < N_LANES; k++) begin
      pop = pop + (CNT_W+1)'(det_q[k]);
    end
    skip_sum  = {1'b0, skip_q} + pop;
    total_sum = {1'b0, total_q} + (CNT_W+1)'(N_LANES);
  end

  // Saturating statistics; clear takes priority over a coincident transfer
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      skip_q  <= '0;
      total_q <= '0;
    end else if (i_cnt_clr) begin
      skip_q  <= '0;
      total_q <= '0;
    end else if (give) begin
      skip_q  <= skip_sum[CNT_W]  ? '1 : skip_sum[CNT_W-1:0];
      total_q <= total_sum[CNT_W] ? '1 : total_sum[CNT_W-1:0];
    end
  end

  assign bus.o_ready    = ready;
  assign bus.o_valid    = valid_q;
  assign bus.o_a        = a_q;
  assign bus.o_b        = b_q;
  assign bus.o_zero_det = det_q;
  assign o_cfg_ack      = ack;
  assign o_skip_cnt     = skip_q;
  assign o_total_cnt    = total_q;

endmodule
